// File: rtl/set_assoc_cache_model.sv
// set_assoc_cache_model: set-associative cache hit/miss model with LRU ages and saturating stats; optional eviction counter under CACHE_EVICT_CNT_EN
module set_assoc_cache_model #(
  parameter int ADDR_W     = 31,
  parameter int LINE_BYTES = 16,
  parameter int NUM_SETS   = 64,
  parameter int WAYS       = 4,
  parameter int CNT_W      = 31
) (
  input  logic              clk_41,
  input  logic              rst_41,
  input  logic [ADDR_W-1:0] addr_41,
  input  logic              valid_41,
  input  logic              flush_41,
  output logic              hit_41,
  output logic              miss_41,
  output logic [CNT_W-1:0]  hits_41,
  output logic [CNT_W-1:0]  misses_41
`ifdef CACHE_EVICT_CNT_EN
  ,
  output logic [CNT_W-1:0]  evicts_41
`endif
);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int WAY_W = WAYS > 1 ? $clog2(WAYS) : 1;
  logic [WAYS-1:0]  r_valid [NUM_SETS];
  logic [TAG_W-1:0] r_tag   [NUM_SETS][WAYS];
  logic [WAY_W-1:0] r_age   [NUM_SETS][WAYS];
  logic             r_hit, r_miss;
  logic [CNT_W-1:0] r_hits, r_misses;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_acc, w_hit, w_inv;
  logic [WAY_W-1:0] w_hway, w_iway, w_lway, w_way, w_old;
  logic             w_unused_off;
  assign w_idx        = addr_41[OFF_W +: IDX_W];
  assign w_tag        = addr_41[ADDR_W-1 -: TAG_W];
  assign w_unused_off = ^addr_41[OFF_W-1:0];
  assign w_acc        = valid_41 && !flush_41;
  assign w_way        = w_hit ? w_hway : (w_inv ? w_iway : w_lway);
  assign w_old        = r_age[w_idx][w_way];
  assign hit_41       = r_hit;
  assign miss_41      = r_miss;
  assign hits_41      = r_hits;
  assign misses_41    = r_misses;
  // Set lookup: matching way, lowest-index invalid way and the oldest way; descending scan lets the lowest index win
  always_comb begin
    w_hit  = 1'b0;
    w_inv  = 1'b0;
    w_hway = '0;
    w_iway = '0;
    w_lway = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (r_valid[w_idx][i] && r_tag[w_idx][i] == w_tag) begin
        w_hit  = 1'b1;
        w_hway = WAY_W'(i);
      end
      if (!r_valid[w_idx][i]) begin
        w_inv  = 1'b1;
        w_iway = WAY_W'(i);
      end
      if (r_age[w_idx][i] == WAY_W'(WAYS - 1)) w_lway = WAY_W'(i);
    end
  end
  // Tag fill on a miss; tags need no reset because valid bits gate them
  always_ff @(posedge clk_41) begin
    if (w_acc && !w_hit) r_tag[w_idx][w_way] <= w_tag;
  end
  // Valid bits, LRU ages, pulses and saturating counters
  always_ff @(posedge clk_41 or posedge rst_41) begin
    if (rst_41) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        for (int j = 0; j < WAYS; j++) r_age[s][j] <= WAY_W'(j);
      end
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;
      r_hits   <= '0;
      r_misses <= '0;
    end else begin
      r_hit  <= w_acc && w_hit;
      r_miss <= w_acc && !w_hit;
      if (flush_41)
        for (int s = 0; s < NUM_SETS; s++) r_valid[s] <= '0;
      if (w_acc) begin
        if (!w_hit) r_valid[w_idx][w_way] <= 1'b1;
        for (int j = 0; j < WAYS; j++)
          if (r_age[w_idx][j] < w_old) r_age[w_idx][j] <= r_age[w_idx][j] + 1'b1;
        r_age[w_idx][w_way] <= '0;
        if (w_hit && r_hits != '1) r_hits <= r_hits + 1'b1;
        if (!w_hit && r_misses != '1) r_misses <= r_misses + 1'b1;
      end
    end
  end
`ifdef CACHE_EVICT_CNT_EN
  logic [CNT_W-1:0] r_evicts;
  assign evicts_41 = r_evicts;
  // A miss with no invalid way replaces a valid line
  always_ff @(posedge clk_41 or posedge rst_41) begin
    if (rst_41) r_evicts <= '0;
    else if (w_acc && !w_hit && !w_inv && r_evicts != '1) r_evicts <= r_evicts + 1'b1;
  end
`endif
endmodule

// File: tb/tb_set_assoc_cache_model.sv
// tb_set_assoc_cache_model: random and directed checks against a true-LRU list model
module tb_set_assoc_cache_model;
  localparam int AW = 10, LB = 16, NS = 4, WY = 2, OW = 4, IW = 2, TW = 4;
  logic clk = 0, rst = 1, valid = 0, flush = 0;
  logic [AW-1:0] addr = '0;
  logic hit, miss, s_hit, s_miss;
  logic [7:0] hits, misses;
  logic [3:0] s_hits, s_misses;
`ifdef CACHE_EVICT_CNT_EN
  logic [7:0] evicts;
  logic [3:0] s_evicts;
`endif
  set_assoc_cache_model #(.ADDR_W(AW), .LINE_BYTES(LB), .NUM_SETS(NS), .WAYS(WY), .CNT_W(8)) u_dut (
    .clk_41(clk), .rst_41(rst), .addr_41(addr), .valid_41(valid), .flush_41(flush),
    .hit_41(hit), .miss_41(miss), .hits_41(hits), .misses_41(misses)
`ifdef CACHE_EVICT_CNT_EN
    , .evicts_41(evicts)
`endif
  );
  set_assoc_cache_model #(.ADDR_W(AW), .LINE_BYTES(LB), .NUM_SETS(NS), .WAYS(WY), .CNT_W(4)) u_sat (
    .clk_41(clk), .rst_41(rst), .addr_41(addr), .valid_41(valid), .flush_41(flush),
    .hit_41(s_hit), .miss_41(s_miss), .hits_41(s_hits), .misses_41(s_misses)
`ifdef CACHE_EVICT_CNT_EN
    , .evicts_41(s_evicts)
`endif
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0;
  logic [TW-1:0] lru [NS][$];
  int m_h = 0, m_m = 0, m_e = 0;
  logic e_hit = 0, e_miss = 0;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] sat(int v, int w);
    return (v > (1 << w) - 1) ? 64'((1 << w) - 1) : 64'(v);
  endfunction
  task automatic model(logic v, logic f, logic [AW-1:0] a);
    int s, pos;
    logic [TW-1:0] t;
    e_hit = 0;
    e_miss = 0;
    if (f) begin
      for (int i = 0; i < NS; i++) lru[i].delete();
    end else if (v) begin
      s = int'(a[OW +: IW]);
      t = a[AW-1 -: TW];
      pos = -1;
      for (int i = 0; i < lru[s].size(); i++) if (lru[s][i] == t) pos = i;
      if (pos >= 0) begin
        e_hit = 1;
        m_h++;
        lru[s].delete(pos);
      end else begin
        e_miss = 1;
        m_m++;
        if (lru[s].size() == WY) begin
          void'(lru[s].pop_back());
          m_e++;
        end
      end
      lru[s].push_front(t);
    end
  endtask
  task automatic check_all(string tag);
    chk({tag, ".hit"}, 64'(hit), 64'(e_hit));
    chk({tag, ".miss"}, 64'(miss), 64'(e_miss));
    chk({tag, ".hits"}, 64'(hits), sat(m_h, 8));
    chk({tag, ".misses"}, 64'(misses), sat(m_m, 8));
    chk({tag, ".s_hit"}, 64'(s_hit), 64'(e_hit));
    chk({tag, ".s_hits"}, 64'(s_hits), sat(m_h, 4));
    chk({tag, ".s_misses"}, 64'(s_misses), sat(m_m, 4));
`ifdef CACHE_EVICT_CNT_EN
    chk({tag, ".evicts"}, 64'(evicts), sat(m_e, 8));
    chk({tag, ".s_evicts"}, 64'(s_evicts), sat(m_e, 4));
`endif
  endtask
  task automatic cyc(logic v, logic f, logic [AW-1:0] a, string tag);
    valid = v;
    flush = f;
    addr = a;
    model(v, f, a);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask
  task automatic do_rst();
    rst = 1;
    valid = 0;
    flush = 0;
    #2;
    for (int i = 0; i < NS; i++) lru[i].delete();
    m_h = 0;
    m_m = 0;
    m_e = 0;
    e_hit = 0;
    e_miss = 0;
    check_all("rst");
    rst = 0;
  endtask
  initial begin
    do_rst();
    cyc(1, 0, 10'd0, "r30a");
    cyc(1, 0, 10'd4, "r30b");
    chk("r30.hit", 64'(hit), 1);
    chk("r30.hits", 64'(hits), 1);
    chk("r30.misses", 64'(misses), 1);
    do_rst();
    cyc(1, 0, 10'd0, "r31a");
    cyc(1, 0, 10'd64, "r31b");
    cyc(1, 0, 10'd128, "r31c");
    cyc(1, 0, 10'd0, "r31d");
    chk("r31.misses", 64'(misses), 4);
`ifdef CACHE_EVICT_CNT_EN
    chk("r31.evicts", 64'(evicts), 2);
`endif
    do_rst();
    cyc(1, 0, 10'd0, "r32a");
    cyc(1, 0, 10'd64, "r32b");
    cyc(1, 0, 10'd0, "r32c");
    cyc(1, 0, 10'd128, "r32d");
    cyc(1, 0, 10'd0, "r32e");
    chk("r32.hits", 64'(hits), 2);
    chk("r32.misses", 64'(misses), 3);
    cyc(1, 0, 10'd64, "r32f");
    chk("r32.evicted_miss", 64'(miss), 1);
    do_rst();
    cyc(1, 0, 10'd0, "r33a");
    cyc(0, 1, 10'd0, "r33b");
    cyc(1, 0, 10'd0, "r33c");
    chk("r33.refill_miss", 64'(miss), 1);
    cyc(1, 1, 10'd0, "r33d");
    chk("r33.drop_pulse", 64'(hit | miss), 0);
    chk("r33.misses", 64'(misses), 2);
    chk("r33.hits", 64'(hits), 0);
    do_rst();
    for (int i = 0; i < 20; i++) cyc(1, 0, 10'd0, "r34");
    chk("r34.s_misses", 64'(s_misses), 1);
    chk("r34.s_hits", 64'(s_hits), 15);
    chk("r34.hits", 64'(hits), 19);
    cyc(1, 0, 10'd16, "r35a");
    valid = 1;
    do_rst();
    chk("r35.hits0", 64'(hits), 0);
    chk("r35.misses0", 64'(misses), 0);
    cyc(1, 0, 10'd0, "r35b");
    chk("r35.miss", 64'(miss), 1);
    cyc(0, 0, 10'd0, "idle");
    chk("idle.pulse", 64'(hit | miss), 0);
    for (int i = 0; i < 600; i++) begin
      logic [AW-1:0] a;
      a = {4'($urandom_range(0, 5)), 2'($urandom), 4'($urandom)};
      if ($urandom_range(0, 199) == 0) do_rst();
      else cyc(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 24) == 0), a, "rnd");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
